// File: rtl/count_mon_pkg.sv
// ============================================================================
// Module   : count_mon_pkg
// Purpose  : Shared widths, reset values and FSM state type for the monitor.
// Revision : 1.0
// ============================================================================
`default_nettype none

package count_mon_pkg;

    localparam int             CNT_W   = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = 4'd15;
    localparam logic [CNT_W-1:0] CMP_RST = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_PENDING = 2'd2
    } mon_state_e;

endpackage

`default_nettype wire

// File: rtl/cnt_wrap_detect.sv
// ============================================================================
// Module   : cnt_wrap_detect
// Purpose  : Registers the previous count and flags 15->0 wraps and changes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cnt_wrap_detect
    import count_mon_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] cnt_i,
    output logic             wrap_o,
    output logic             chg_o
);

    logic [CNT_W-1:0] cnt_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_prev_q <= '0;
        end else begin
            cnt_prev_q <= cnt_i;
        end
    end

    assign wrap_o = (cnt_prev_q == CNT_MAX) && (cnt_i == '0);
    assign chg_o  = (cnt_i != cnt_prev_q);

endmodule

`default_nettype wire

// File: rtl/count_event_monitor.sv
// ============================================================================
// Module   : count_event_monitor
// Purpose  : Wrap/compare event monitor for a 4-bit counter with capture FSM.
//            Optional PWM output when COUNT_EVENT_MONITOR_PWM_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module count_event_monitor
    import count_mon_pkg::*;
#(
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CNT_W-1:0]  cnt_in,
    input  logic [CNT_W-1:0]  cmp_in,
    input  logic              cmp_load,
    input  logic              arm,
    input  logic              evt_ack,
    output logic              wrap_pulse,
    output logic              match_pulse,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              evt_valid,
    output logic [WRAP_W-1:0] evt_wrap,
    output logic              evt_ovr,
    output logic              pwm_out
);

    logic              wrap_det;
    logic              chg_det;
    logic              match_det;
    logic [CNT_W-1:0]  cmp_q,      cmp_d;
    logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic              wrap_pulse_q;
    logic              match_pulse_q;
    mon_state_e        state_q;
    logic              evt_valid_q;
    logic [WRAP_W-1:0] evt_wrap_q;
    logic              evt_ovr_q;

    cnt_wrap_detect u_det (
        .clk    (clk),
        .rst    (rst),
        .cnt_i  (cnt_in),
        .wrap_o (wrap_det),
        .chg_o  (chg_det)
    );

    // A stalled counter holds its value, so requiring a change blocks re-triggers.
    assign match_det  = chg_det && (cnt_in == cmp_q);
    assign cmp_d      = cmp_load ? cmp_in : cmp_q;
    assign wrap_cnt_d = (wrap_det && (wrap_cnt_q != {WRAP_W{1'b1}}))
                        ? wrap_cnt_q + WRAP_W'(1) : wrap_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_q         <= CMP_RST;
            wrap_cnt_q    <= '0;
            wrap_pulse_q  <= 1'b0;
            match_pulse_q <= 1'b0;
        end else begin
            cmp_q         <= cmp_d;
            wrap_cnt_q    <= wrap_cnt_d;
            wrap_pulse_q  <= wrap_det;
            match_pulse_q <= match_det;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            evt_valid_q <= 1'b0;
            evt_wrap_q  <= '0;
            evt_ovr_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arm) begin
                        state_q <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (match_det) begin
                        state_q     <= ST_PENDING;
                        evt_valid_q <= 1'b1;
                        // Post-increment value so a coincident wrap is included.
                        evt_wrap_q  <= wrap_cnt_d;
                    end
                end
                ST_PENDING: begin
                    if (evt_ack) begin
                        state_q     <= arm ? ST_ARMED : ST_IDLE;
                        evt_valid_q <= 1'b0;
                        evt_ovr_q   <= 1'b0;
                    end else if (match_det) begin
                        evt_ovr_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    evt_valid_q <= 1'b0;
                    evt_ovr_q   <= 1'b0;
                end
            endcase
        end
    end

`ifdef COUNT_EVENT_MONITOR_PWM_EN
    logic pwm_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_q <= 1'b0;
        end else begin
            pwm_q <= (cnt_in < cmp_q);
        end
    end

    assign pwm_out = pwm_q;
`else
    assign pwm_out = 1'b0;
`endif

    assign wrap_pulse  = wrap_pulse_q;
    assign match_pulse = match_pulse_q;
    assign wrap_cnt    = wrap_cnt_q;
    assign evt_valid   = evt_valid_q;
    assign evt_wrap    = evt_wrap_q;
    assign evt_ovr     = evt_ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_count_event_monitor.sv
// ============================================================================
// Module   : tb_count_event_monitor
// Purpose  : Scoreboard bench for count_event_monitor (WRAP_W=8 and WRAP_W=2).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_count_event_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] cnt_in = 4'd0;
    logic [3:0] cmp_in = 4'd0;
    logic       cmp_load = 1'b0;
    logic       arm = 1'b0;
    logic       evt_ack = 1'b0;

    logic       wrap_pulse, match_pulse, evt_valid, evt_ovr, pwm_out;
    logic [7:0] wrap_cnt, evt_wrap;
    logic       b_wrap_pulse, b_match_pulse, b_evt_valid, b_evt_ovr, b_pwm_out;
    logic [1:0] b_wrap_cnt, b_evt_wrap;

    always #5 clk = ~clk;

    count_event_monitor #(.WRAP_W(8)) dut (
        .clk(clk), .rst(rst), .cnt_in(cnt_in), .cmp_in(cmp_in),
        .cmp_load(cmp_load), .arm(arm), .evt_ack(evt_ack),
        .wrap_pulse(wrap_pulse), .match_pulse(match_pulse), .wrap_cnt(wrap_cnt),
        .evt_valid(evt_valid), .evt_wrap(evt_wrap), .evt_ovr(evt_ovr),
        .pwm_out(pwm_out)
    );

    count_event_monitor #(.WRAP_W(2)) dut_w2 (
        .clk(clk), .rst(rst), .cnt_in(cnt_in), .cmp_in(cmp_in),
        .cmp_load(cmp_load), .arm(arm), .evt_ack(evt_ack),
        .wrap_pulse(b_wrap_pulse), .match_pulse(b_match_pulse), .wrap_cnt(b_wrap_cnt),
        .evt_valid(b_evt_valid), .evt_wrap(b_evt_wrap), .evt_ovr(b_evt_ovr),
        .pwm_out(b_pwm_out)
    );

    typedef struct {
        logic       wp;
        logic       mp;
        logic [7:0] wc8;
        logic [1:0] wc2;
        logic       ev;
        logic [7:0] ew8;
        logic [1:0] ew2;
        logic       ovr;
        logic       pwm;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: plain bookkeeping of the behavioural rules.
    int         m_prev = 0;
    int         m_cmp  = 8;
    int         m_wc8  = 0;
    int         m_wc2  = 0;
    int         m_ew8  = 0;
    int         m_ew2  = 0;
    bit         m_armed = 0;
    bit         m_pend  = 0;
    bit         m_ovr   = 0;
    logic [3:0] cq = 4'd0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int c, input int ci, input bit ld,
                              input bit a, input bit k, input bit r);
        exp_t e;
        bit   wrap, match;
        if (r) begin
            m_prev = 0; m_cmp = 8; m_wc8 = 0; m_wc2 = 0; m_ew8 = 0; m_ew2 = 0;
            m_armed = 0; m_pend = 0; m_ovr = 0;
            wrap = 0; match = 0;
            e.pwm = 1'b0;
        end else begin
            wrap  = (m_prev == 15) && (c == 0);
            match = (c != m_prev) && (c == m_cmp);
`ifdef COUNT_EVENT_MONITOR_PWM_EN
            e.pwm = (c < m_cmp);
`else
            e.pwm = 1'b0;
`endif
            if (wrap) begin
                m_wc8 = (m_wc8 < 255) ? m_wc8 + 1 : 255;
                m_wc2 = (m_wc2 < 3)   ? m_wc2 + 1 : 3;
            end
            if (m_pend) begin
                if (k) begin
                    m_pend = 0; m_ovr = 0; m_armed = a;
                end else if (match) begin
                    m_ovr = 1;
                end
            end else if (m_armed) begin
                if (match) begin
                    m_armed = 0; m_pend = 1; m_ew8 = m_wc8; m_ew2 = m_wc2;
                end
            end else if (a) begin
                m_armed = 1;
            end
            if (ld) m_cmp = ci;
            m_prev = c;
        end
        e.wp  = wrap;
        e.mp  = match;
        e.wc8 = 8'(m_wc8);
        e.wc2 = 2'(m_wc2);
        e.ev  = m_pend;
        e.ew8 = 8'(m_ew8);
        e.ew2 = 2'(m_ew2);
        e.ovr = m_ovr;
        sbq.push_back(e);
    endtask

    task automatic cyc(input logic [3:0] c, input logic [3:0] ci, input bit ld,
                       input bit a, input bit k, input bit r);
        @(negedge clk);
        cnt_in = c; cmp_in = ci; cmp_load = ld; arm = a; evt_ack = k; rst = r;
        model_step(int'(c), int'(ci), ld, a, k, r);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            cq = cq + 4'd1;
            cyc(cq, 4'd0, 0, 0, 0, 0);
        end
    endtask

    task automatic do_reset();
        cq = 4'd0;
        for (int i = 0; i < 2; i++) cyc(4'd0, 4'd0, 0, 0, 0, 1);
        cyc(4'd0, 4'd0, 0, 0, 0, 0);
    endtask

    exp_t mon_e;
    always @(posedge clk) begin
        #1;
        if (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            chk("wrap_pulse",    {7'd0, wrap_pulse},    {7'd0, mon_e.wp});
            chk("match_pulse",   {7'd0, match_pulse},   {7'd0, mon_e.mp});
            chk("wrap_cnt",      wrap_cnt,              mon_e.wc8);
            chk("evt_valid",     {7'd0, evt_valid},     {7'd0, mon_e.ev});
            chk("evt_wrap",      evt_wrap,              mon_e.ew8);
            chk("evt_ovr",       {7'd0, evt_ovr},       {7'd0, mon_e.ovr});
            chk("pwm_out",       {7'd0, pwm_out},       {7'd0, mon_e.pwm});
            chk("w2_wrap_pulse", {7'd0, b_wrap_pulse},  {7'd0, mon_e.wp});
            chk("w2_match_pulse",{7'd0, b_match_pulse}, {7'd0, mon_e.mp});
            chk("w2_wrap_cnt",   {6'd0, b_wrap_cnt},    {6'd0, mon_e.wc2});
            chk("w2_evt_valid",  {7'd0, b_evt_valid},   {7'd0, mon_e.ev});
            chk("w2_evt_wrap",   {6'd0, b_evt_wrap},    {6'd0, mon_e.ew2});
            chk("w2_evt_ovr",    {7'd0, b_evt_ovr},     {7'd0, mon_e.ovr});
            chk("w2_pwm_out",    {7'd0, b_pwm_out},     {7'd0, mon_e.pwm});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pwm_hi;
        int pwm_exp;

        // Two full laps of the counter.
        do_reset();
        run(32);
        @(posedge clk); #2;
        chk("two_wraps_cnt", wrap_cnt, 8'd2);

        // Compare at 5, capture, overrun on the next lap, then acknowledge.
        cyc(cq, 4'd5, 1, 0, 0, 0);
        cyc(cq, 4'd0, 0, 1, 0, 0);
        run(20);
        run(16);
        @(posedge clk); #2;
        chk("ovr_before_ack", {7'd0, evt_ovr}, 8'd1);
        cyc(cq, 4'd0, 0, 0, 1, 0);
        run(3);

        // Compare at 0: capture coincides with a wrap.
        do_reset();
        cyc(cq, 4'd0, 1, 1, 0, 0);
        run(16);
        @(posedge clk); #2;
        chk("coincide_evt_wrap", evt_wrap, 8'd1);
        cyc(cq, 4'd0, 0, 1, 1, 0);

        // Saturation of the narrow instance after five wraps.
        do_reset();
        run(16 * 5 + 2);
        @(posedge clk); #2;
        chk("w2_saturated", {6'd0, b_wrap_cnt}, 8'd3);

        // Reset while an event is pending.
        cyc(cq, 4'd3, 1, 1, 0, 0);
        run(16);
        do_reset();
        run(4);

        // PWM duty with compare 4.
        do_reset();
        cyc(cq, 4'd4, 1, 0, 0, 0);
        pwm_hi = 0;
        for (int i = 0; i < 16; i++) begin
            cq = cq + 4'd1;
            cyc(cq, 4'd0, 0, 0, 0, 0);
            @(posedge clk); #2;
            if (pwm_out === 1'b1) pwm_hi++;
        end
`ifdef COUNT_EVENT_MONITOR_PWM_EN
        pwm_exp = 4;
`else
        pwm_exp = 0;
`endif
        chk("pwm_duty", 8'(pwm_hi), 8'(pwm_exp));

        // Randomized traffic: stalls, jumps, loads, arm/ack, occasional reset.
        for (int i = 0; i < 1500; i++) begin
            bit         ld, a, k, r;
            logic [3:0] ci;
            if ($urandom_range(0, 39) == 0) cq = 4'($urandom_range(0, 15));
            else if ($urandom_range(0, 3) != 0) cq = cq + 4'd1;
            ld = ($urandom_range(0, 24) == 0);
            ci = 4'($urandom_range(0, 15));
            a  = ($urandom_range(0, 5) == 0);
            k  = ($urandom_range(0, 4) == 0);
            r  = ($urandom_range(0, 199) == 0);
            if (r) cq = 4'd0;
            cyc(cq, ci, ld, a, k, r);
        end

        cyc(cq, 4'd0, 0, 0, 0, 0);
        @(posedge clk); #2;
        chk("scoreboard_drained", 8'(sbq.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/count_event_monitor.md
COUNT_EVENT_MONITOR -- requirements
Module: count_event_monitor

Interface
REQ-001 SHALL have parameter WRAP_W, default 8, width of the wrap counter and the captured event value.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port cnt_in  input  4  count value Q from the upstream 4-bit synchronous up-counter.
REQ-005 SHALL have port cmp_in  input  4  compare value, loaded when cmp_load=1.
REQ-006 SHALL have port cmp_load  input  1  load strobe for cmp_in.
REQ-007 SHALL have port arm  input  1  request to arm event capture.
REQ-008 SHALL have port evt_ack  input  1  consumer acknowledge of a pending event.
REQ-009 SHALL have port wrap_pulse  output  1  one-cycle pulse per detected 15->0 wrap.
REQ-010 SHALL have port match_pulse  output  1  one-cycle pulse per new compare match.
REQ-011 SHALL have port wrap_cnt  output  WRAP_W  saturating wrap count.
REQ-012 SHALL have port evt_valid  output  1  event pending.
REQ-013 SHALL have port evt_wrap  output  WRAP_W  wrap_cnt captured at the event.
REQ-014 SHALL have port evt_ovr  output  1  sticky: match occurred while event pending.
REQ-015 SHALL have port pwm_out  output  1  registered PWM derived from cnt_in vs compare.

Function
REQ-016 SHALL register cnt_in into cnt_prev every cycle.
REQ-017 SHALL assert wrap_pulse for exactly one cycle, on the edge after sampling cnt_prev=15 and cnt_in=0 (latency 1).
REQ-018 SHALL hold cmp_reg; cmp_load updates it on the next edge, and the new value applies to compares from the following cycle.
REQ-019 SHALL assert match_pulse one cycle after sampling cnt_in==cmp_reg with cnt_in!=cnt_prev; a stalled counter SHALL NOT re-trigger.
REQ-020 SHALL increment wrap_cnt by 1 on each detected wrap, saturating at 2^WRAP_W-1 with no wrap-around.
REQ-021 SHALL implement FSM IDLE, ARMED, PENDING: IDLE->ARMED on arm; ARMED->PENDING on match detect; PENDING->IDLE on evt_ack, or ->ARMED if arm=1 in the same cycle as evt_ack.
REQ-022 SHALL assert evt_valid exactly while in PENDING, with evt_wrap stable from entry until acknowledge.
REQ-023 SHALL load evt_wrap with the post-increment wrap_cnt when wrap and match are detected in the same cycle.
REQ-024 SHALL set evt_ovr on a match detected while in PENDING, and clear it on evt_ack.
REQ-025 SHALL ignore evt_ack outside PENDING and arm outside IDLE, except as stated in REQ-021.
REQ-026 SHALL drive pwm_out=1 on the edge after sampling cnt_in<cmp_reg: cmp_reg=0 gives constant 0; cmp_reg=15 gives 15 of 16 cycles high.

Reset
REQ-027 SHALL on rst=1 set state IDLE, cnt_prev=0, cmp_reg=8, wrap_cnt=0, evt_wrap=0, and all 1-bit outputs 0, overriding all other inputs that cycle.
REQ-028 SHALL NOT detect a wrap or match on the first edge after rst deasserts, because cnt_prev=0 and cnt_in=0 give no change.

Configuration
REQ-029 SHALL compile the PWM path only when COUNT_EVENT_MONITOR_PWM_EN is defined; otherwise pwm_out SHALL be tied 0 and no PWM register instantiated.

Structure
REQ-030 SHALL take from package count_mon_pkg: CNT_W=4, CNT_MAX=15, CMP_RST=8, and the FSM state enum.
REQ-031 SHALL place wrap and edge detection (cnt_prev, wrap and change flags) in sub-module cnt_wrap_detect.

Verification
REQ-032 SHALL verify: counter free-runs 0..15 twice -> two wrap_pulse, each one cycle after cnt_in=0 is sampled; wrap_cnt=2.
REQ-033 SHALL verify: cmp_load with cmp_in=5, arm, counter runs -> evt_valid one cycle after cnt_in=5 is sampled; evt_wrap holds its value until evt_ack; then state IDLE.
REQ-034 SHALL verify: cmp=0, armed, counter wraps 15->0 -> wrap and match pulses in the same cycle; evt_wrap equals the incremented wrap_cnt.
REQ-035 SHALL verify: event pending, no ack, further matches -> evt_ovr=1; evt_ack clears evt_ovr and evt_valid.
REQ-036 SHALL verify: WRAP_W=2 and 5 wraps -> wrap_cnt saturates at 3.
REQ-037 SHALL verify: rst mid-PENDING with counter also reset -> all outputs 0, no spurious pulse; with macro defined, cmp=4 -> pwm_out high 4 of 16 cycles.
